// File: rtl/img_pkg.sv
// Shared types and constants for the frame-buffer reader pipeline.
package img_pkg;

    typedef enum logic {
        SCALE_1X = 1'b0,
        SCALE_2X = 1'b1
    } scale_e;

    // Control bits that travel alongside the pixel through the read latency.
    typedef struct packed {
        logic in_win;
        logic de;
        logic h_sync;
        logic v_sync;
    } ctrl_t;

    localparam int R_MSB = 15;
    localparam int G_MSB = 10;
    localparam int B_MSB = 4;

    localparam int QVGA_W = 320;
    localparam int QVGA_H = 240;
    localparam int VGA_W  = 640;
    localparam int VGA_H  = 480;

    // On-screen extent of a source dimension; 11 bits so window ends never wrap.
    function automatic logic [10:0] win_span(input scale_e scale, input logic [9:0] len);
        return (scale == SCALE_2X) ? {len, 1'b0} : {1'b0, len};
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with synchronous clear, used to align control with read data.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/img_reader_pipe.sv
// Frame-buffer reader: maps display coordinates into a windowed, optionally 2x-scaled
// source image and re-aligns DE/syncs with the RGB565 read data.
module img_reader_pipe
    import img_pkg::*;
#(
    parameter int SRC_W   = QVGA_W,
    parameter int SRC_H   = QVGA_H,
    parameter int DISP_W  = VGA_W,
    parameter int DISP_H  = VGA_H,
    parameter int RD_LAT  = 1,
    parameter int ADDR_W  = 17,
    parameter int COLOR_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               DE,
    input  logic               h_sync,
    input  logic               v_sync,
    input  logic [9:0]         x_pixel,
    input  logic [9:0]         y_pixel,
    input  logic               scale_sel,
    input  logic [9:0]         win_x,
    input  logic [9:0]         win_y,
    output logic [ADDR_W-1:0]  addr,
    output logic               rd_en,
    input  logic [15:0]        data,
    output logic [COLOR_W-1:0] r_port,
    output logic [COLOR_W-1:0] g_port,
    output logic [COLOR_W-1:0] b_port,
    output logic               DE_out,
    output logic               h_sync_out,
    output logic               v_sync_out
);

    localparam logic [10:0] SRC_W_L  = 11'(SRC_W);
    localparam logic [10:0] SRC_H_L  = 11'(SRC_H);
    localparam logic [10:0] DISP_W_L = 11'(DISP_W);
    localparam logic [10:0] DISP_H_L = 11'(DISP_H);
    localparam logic [31:0] SRC_W_32 = 32'(SRC_W);

    scale_e            scale_sh;
    logic [9:0]        win_x_sh;
    logic [9:0]        win_y_sh;

    logic [10:0]       x_w;
    logic [10:0]       y_w;
    logic [10:0]       x_end;
    logic [10:0]       y_end;
    logic              in_win;
    logic [9:0]        x_off;
    logic [9:0]        y_off;
    logic [9:0]        col;
    logic [9:0]        row;
    logic [ADDR_W-1:0] addr_next;

    ctrl_t             ctrl_s1;
    ctrl_t             ctrl_dly;

    logic              unused_data;
    assign unused_data = ^data;

    // Config only moves during vertical blanking so a frame is never torn.
    always_ff @(posedge clk) begin
        if (reset) begin
            scale_sh <= SCALE_2X;
            win_x_sh <= '0;
            win_y_sh <= '0;
        end else if ({1'b0, y_pixel} >= DISP_H_L) begin
            scale_sh <= scale_e'(scale_sel);
            win_x_sh <= win_x;
            win_y_sh <= win_y;
        end
    end

    always_comb begin
        x_w    = {1'b0, x_pixel};
        y_w    = {1'b0, y_pixel};
        x_end  = {1'b0, win_x_sh} + win_span(scale_sh, SRC_W_L[9:0]);
        y_end  = {1'b0, win_y_sh} + win_span(scale_sh, SRC_H_L[9:0]);
        in_win = DE
               && (x_w >= {1'b0, win_x_sh}) && (x_w < x_end)
               && (y_w >= {1'b0, win_y_sh}) && (y_w < y_end)
               && (x_w < DISP_W_L) && (y_w < DISP_H_L);

        x_off = x_pixel - win_x_sh;
        y_off = y_pixel - win_y_sh;
        col   = (scale_sh == SCALE_2X) ? {1'b0, x_off[9:1]} : x_off;
        row   = (scale_sh == SCALE_2X) ? {1'b0, y_off[9:1]} : y_off;

        addr_next = ADDR_W'({22'd0, row} * SRC_W_32 + {22'd0, col});
    end

    // Address holds outside the window so the BRAM port sees no spurious toggling.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr    <= '0;
            rd_en   <= 1'b0;
            ctrl_s1 <= '0;
        end else begin
            rd_en          <= in_win;
            if (in_win) begin
                addr <= addr_next;
            end
            ctrl_s1.in_win <= in_win;
            ctrl_s1.de     <= DE;
            ctrl_s1.h_sync <= h_sync;
            ctrl_s1.v_sync <= v_sync;
        end
    end

    pipe_delay #(
        .WIDTH ($bits(ctrl_t)),
        .DEPTH (RD_LAT)
    ) u_align (
        .clk   (clk),
        .reset (reset),
        .din   (ctrl_s1),
        .dout  (ctrl_dly)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_port     <= '0;
            g_port     <= '0;
            b_port     <= '0;
            DE_out     <= 1'b0;
            h_sync_out <= 1'b0;
            v_sync_out <= 1'b0;
        end else begin
            r_port     <= ctrl_dly.in_win ? data[R_MSB -: COLOR_W] : '0;
            g_port     <= ctrl_dly.in_win ? data[G_MSB -: COLOR_W] : '0;
            b_port     <= ctrl_dly.in_win ? data[B_MSB -: COLOR_W] : '0;
            DE_out     <= ctrl_dly.de;
            h_sync_out <= ctrl_dly.h_sync;
            v_sync_out <= ctrl_dly.v_sync;
        end
    end

endmodule

// File: tb/tb_img_reader_pipe.sv
// Bench for img_reader_pipe: RD_LAT=1 and RD_LAT=3 instances against a coordinate-level reference model.
module tb_img_reader_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, de, hs, vs, scale_sel;
    logic [9:0]  x_pixel, y_pixel, win_x, win_y;

    logic [16:0] addr_a, addr_b;
    logic        rd_en_a, rd_en_b;
    logic [15:0] data_a, data_b, b1, b2;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic        de_a, hs_a, vs_a, de_b, hs_b, vs_b;

    logic [15:0] mem [131072];

    img_reader_pipe #(.RD_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .DE(de), .h_sync(hs), .v_sync(vs),
        .x_pixel(x_pixel), .y_pixel(y_pixel), .scale_sel(scale_sel),
        .win_x(win_x), .win_y(win_y), .addr(addr_a), .rd_en(rd_en_a), .data(data_a),
        .r_port(r_a), .g_port(g_a), .b_port(b_a),
        .DE_out(de_a), .h_sync_out(hs_a), .v_sync_out(vs_a)
    );

    img_reader_pipe #(.RD_LAT(3)) dut_b (
        .clk(clk), .reset(reset), .DE(de), .h_sync(hs), .v_sync(vs),
        .x_pixel(x_pixel), .y_pixel(y_pixel), .scale_sel(scale_sel),
        .win_x(win_x), .win_y(win_y), .addr(addr_b), .rd_en(rd_en_b), .data(data_b),
        .r_port(r_b), .g_port(g_b), .b_port(b_b),
        .DE_out(de_b), .h_sync_out(hs_b), .v_sync_out(vs_b)
    );

    // Synchronous-read frame buffers with latency 1 and 3.
    always @(posedge clk) data_a <= mem[addr_a];
    always @(posedge clk) begin
        b1     <= mem[addr_b];
        b2     <= b1;
        data_b <= b2;
    end

    typedef struct {
        bit rst;
        bit iw;
        int addr;
        bit de;
        bit hs;
        bit vs;
    } ent_t;

    ent_t hist[$];
    bit   sh_s2;
    int   sh_wx, sh_wy, last_addr;
    int   errors, checks;

    function automatic logic [11:0] rgb_of(input int a);
        int w;
        w = int'(mem[a]);
        return 12'(((w >> 12) & 15) * 256 + ((w >> 7) & 15) * 16 + ((w >> 1) & 15));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs after edge n reflect the inputs of step n-(L+1), unless a reset intervened.
    task automatic chk_out(input int lat, input string tag, input logic [11:0] rgb, input logic [2:0] syn);
        int n, m;
        bit z;
        logic [11:0] er;
        logic [2:0]  es;
        n = hist.size() - 1;
        m = n - (lat + 1);
        z = (m < 0);
        if (!z) begin
            for (int k = m; k <= n; k++) if (hist[k].rst) z = 1'b1;
        end
        if (z) begin
            er = '0;
            es = '0;
        end else begin
            es = {hist[m].de, hist[m].hs, hist[m].vs};
            er = hist[m].iw ? rgb_of(hist[m].addr) : 12'h000;
        end
        chk({tag, "_rgb"}, 32'(rgb), 32'(er));
        chk({tag, "_sync"}, 32'(syn), 32'(es));
    endtask

    task automatic step(input int x, input int y, input bit d, input bit h, input bit v, input bit r);
        ent_t e;
        int   s;
        reset   = r;
        x_pixel = 10'(x);
        y_pixel = 10'(y);
        de      = d;
        hs      = h;
        vs      = v;
        s       = sh_s2 ? 2 : 1;
        e.rst   = r;
        e.de    = d;
        e.hs    = h;
        e.vs    = v;
        e.iw    = !r && d && x >= sh_wx && x < sh_wx + s * 320 && y >= sh_wy && y < sh_wy + s * 240
                  && x < 640 && y < 480;
        if (r) last_addr = 0;
        else if (e.iw) last_addr = (((y - sh_wy) / s) * 320 + (x - sh_wx) / s) % 131072;
        e.addr = last_addr;
        hist.push_back(e);
        if (r) begin
            sh_s2 = 1'b1;
            sh_wx = 0;
            sh_wy = 0;
        end else if (y >= 480) begin
            sh_s2 = scale_sel;
            sh_wx = int'(win_x);
            sh_wy = int'(win_y);
        end
        @(posedge clk);
        #1;
        chk("a_rd_en", 32'(rd_en_a), 32'(e.iw));
        chk("a_addr", 32'(addr_a), 32'(e.addr));
        chk("b_rd_en", 32'(rd_en_b), 32'(e.iw));
        chk("b_addr", 32'(addr_b), 32'(e.addr));
        chk_out(1, "a", {r_a, g_a, b_a}, {de_a, hs_a, vs_a});
        chk_out(3, "b", {r_b, g_b, b_b}, {de_b, hs_b, vs_b});
    endtask

    task automatic set_cfg(input bit s, input int wx, input int wy);
        scale_sel = s;
        win_x     = 10'(wx);
        win_y     = 10'(wy);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        sh_s2 = 1'b1; sh_wx = 0; sh_wy = 0; last_addr = 0;
        for (int i = 0; i < 131072; i++) mem[i] = 16'($urandom);
        mem[322] = 16'hF81F;
        set_cfg(1'b1, 0, 0);

        repeat (3) step(0, 0, 0, 0, 0, 1);
        chk("reset_addr", 32'(addr_a), 32'd0);

        // 2x at (0,0): pixel (5,3) is source (2,1)
        step(5, 3, 1, 0, 0, 0);
        chk("plan_addr_322", 32'(addr_a), 32'd322);
        chk("plan_rd_en", 32'(rd_en_a), 32'd1);
        step(6, 3, 1, 0, 0, 0);
        step(7, 3, 1, 0, 0, 0);
        chk("plan_rgb_f0f", 32'({r_a, g_a, b_a}), 32'h0F0F);

        repeat (60) step($urandom_range(0, 700), $urandom_range(0, 479),
                         1'($urandom), 1'($urandom), 1'($urandom), 0);

        // 1x at (160,120), loaded in blanking
        set_cfg(1'b0, 160, 120);
        step(0, 490, 0, 0, 1, 0);
        step(160, 120, 1, 0, 0, 0);
        chk("win1x_first", 32'(addr_a), 32'd0);
        step(479, 359, 1, 0, 0, 0);
        chk("win1x_last", 32'(addr_a), 32'd76799);
        step(480, 359, 1, 0, 0, 0);
        chk("win1x_right_out", 32'(rd_en_a), 32'd0);
        step(159, 120, 1, 0, 0, 0);
        chk("win1x_left_out", 32'(rd_en_a), 32'd0);
        repeat (5) step(0, 121, 0, 0, 0, 0);

        // mid-frame change to 1x must not apply until the next blanking
        set_cfg(1'b1, 0, 0);
        step(0, 500, 0, 0, 1, 0);
        step(10, 100, 1, 0, 0, 0);
        set_cfg(1'b0, 0, 0);
        repeat (6) step($urandom_range(0, 639), $urandom_range(100, 101), 1, 0, 0, 0);
        step(21, 101, 1, 0, 0, 0);
        chk("cfg_still_2x", 32'(addr_a), 32'd16010);
        step(0, 480, 0, 0, 1, 0);
        step(21, 0, 1, 0, 0, 0);
        chk("cfg_now_1x", 32'(addr_a), 32'd21);

        // 2x window at (400,300) clipped by the display
        set_cfg(1'b1, 400, 300);
        step(0, 480, 0, 0, 1, 0);
        step(639, 479, 1, 0, 0, 0);
        chk("clip_last_addr", 32'(addr_a), 32'd28599);
        step(640, 479, 1, 0, 0, 0);
        chk("clip_x640", 32'(rd_en_a), 32'd0);
        step(1023, 479, 1, 0, 0, 0);
        chk("clip_x1023", 32'(rd_en_a), 32'd0);
        repeat (40) step($urandom_range(380, 700), $urandom_range(280, 479),
                         1'($urandom), 1'($urandom), 0, 0);

        // h_sync pulse then DE rise, checked on the RD_LAT=3 instance at 5 cycles
        set_cfg(1'b1, 0, 0);
        step(0, 480, 0, 0, 1, 0);
        repeat (5) step(0, 10, 0, 0, 0, 0);
        step(0, 10, 0, 1, 0, 0);
        step(0, 10, 1, 0, 0, 0);
        step(1, 10, 1, 0, 0, 0);
        step(2, 10, 1, 0, 0, 0);
        chk("b_hs_before", 32'(hs_b), 32'd0);
        step(3, 10, 1, 0, 0, 0);
        chk("b_hs_at5", 32'(hs_b), 32'd1);
        chk("b_de_before", 32'(de_b), 32'd0);
        step(4, 10, 1, 0, 0, 0);
        chk("b_de_at5", 32'(de_b), 32'd1);
        chk("b_first_rgb", 32'({r_b, g_b, b_b}), 32'(rgb_of(1600)));

        // reset held 3 cycles mid-line
        for (int x = 195; x < 200; x++) step(x, 50, 1, 0, 0, 0);
        for (int x = 200; x < 203; x++) step(x, 50, 1, 0, 0, 1);
        chk("rst_mid_rgb", 32'({r_a, g_a, b_a}), 32'd0);
        chk("rst_mid_de", 32'(de_a), 32'd0);
        for (int x = 203; x < 212; x++) step(x, 50, 1, 0, 0, 0);

        // random frames with random configuration, including blanking rows
        for (int blk = 0; blk < 6; blk++) begin
            set_cfg(1'($urandom), $urandom_range(0, 700), $urandom_range(0, 500));
            repeat (50) step($urandom_range(0, 799), $urandom_range(0, 524),
                             1'($urandom), 1'($urandom), 1'($urandom), 0);
        end
        repeat (6) step(0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/img_reader_pipe.md
Name: img_reader_pipe

Overview:
Pipelined, parametrised frame-buffer reader between the VGA timing generator and a synchronous-read RGB565 frame buffer (BRAM).
- Maps display pixel coordinates to a frame-buffer read address for a source image placed in a display window.
- Supports 1x or 2x upscale and a runtime window offset.
- Compensates the buffer read latency by delaying DE, h_sync and v_sync so they stay aligned with the colour outputs.

Parameters:
- SRC_W, 320, source image width in pixels
- SRC_H, 240, source image height in pixels
- DISP_W, 640, visible display width
- DISP_H, 480, visible display height
- RD_LAT, 1, frame-buffer read latency in cycles, from addr to data (1..4)
- ADDR_W, 17, address width
- COLOR_W, 4, output bits per channel (1..5)

Ports:
- clk  in  1  pixel clock, the single clock
- reset  in  1  synchronous, active-high reset
- DE  in  1  display enable from the timing generator
- h_sync  in  1  horizontal sync from the timing generator
- v_sync  in  1  vertical sync from the timing generator
- x_pixel  in  10  display column
- y_pixel  in  10  display row
- scale_sel  in  1  0 = 1x, 1 = 2x; shadowed
- win_x  in  10  window left edge; shadowed
- win_y  in  10  window top edge; shadowed
- addr  out  ADDR_W  frame-buffer read address
- rd_en  out  1  frame-buffer read enable
- data  in  16  RGB565 read data, valid RD_LAT cycles after addr
- r_port  out  COLOR_W  red
- g_port  out  COLOR_W  green
- b_port  out  COLOR_W  blue
- DE_out  out  1  DE delayed to align with the colour outputs
- h_sync_out  out  1  h_sync delayed to align with the colour outputs
- v_sync_out  out  1  v_sync delayed to align with the colour outputs

Behaviour:
- Reset:
  - All pipeline registers and outputs go to 0.
  - Shadow config loads scale = 2x, win = (0,0).
  - Effective from the cycle after reset is sampled high.
- Config shadowing:
  - scale_sel, win_x and win_y are copied into shadow registers on every cycle where y_pixel >= DISP_H (vertical blanking), and only then.
  - Changes mid-frame have no effect until the next blanking period.
- Window: S = 1 or 2 per the shadow scale. in_win is true when all of:
  - DE = 1
  - win_x <= x_pixel < win_x + S*SRC_W
  - win_y <= y_pixel < win_y + S*SRC_H
  - x_pixel < DISP_W and y_pixel < DISP_H
  - Compare with 11-bit sums so the window end cannot wrap.
- Stage 1 (registered, 1 cycle):
  - col = (x_pixel - win_x) >> (S-1); row = (y_pixel - win_y) >> (S-1).
  - addr <= row*SRC_W + col, truncated to ADDR_W bits.
  - rd_en <= in_win.
  - When in_win = 0: rd_en <= 0 and addr holds its previous value. addr is never tristated.
- Stages 2..RD_LAT+1: in_win, DE, h_sync and v_sync are carried in a delay line matched to RD_LAT.
- Output stage (registered), when the delayed in_win = 1:
  - r_port <= data[15 -: COLOR_W]
  - g_port <= data[10 -: COLOR_W]
  - b_port <= data[4 -: COLOR_W]
  - Otherwise all three are 0.
- Latency: exactly RD_LAT+2 cycles, inputs to r/g/b, DE_out, h_sync_out and v_sync_out.
- Throughput: one pixel per cycle, no stalls.
- Boundaries:
  - A window extending past DISP_W or DISP_H is clipped; no address is generated beyond the clipped region.
  - The last source pixel addresses SRC_W*SRC_H-1.
  - With 2x scale, each source pixel is read on 2 consecutive columns and 2 consecutive rows.
- Reset mid-frame: outputs are 0 during reset. Addressing is stateless per pixel, so the first pixel after release is correct, appearing RD_LAT+2 cycles later.

Decomposition:
- Shared package img_pkg holds:
  - scale_e enum {SCALE_1X, SCALE_2X}
  - RGB565 field MSB constants (R_MSB = 15, G_MSB = 10, B_MSB = 4)
  - QVGA and VGA dimension constants
- Sub-module pipe_delay (parameters WIDTH, DEPTH, synchronous reset to 0) is used for the in_win/DE/sync alignment.

Test Plan:
- 2x scale, win (0,0), RD_LAT = 1:
  - x = 5, y = 3 -> addr = 322 and rd_en = 1 one cycle later.
  - data = 16'hF81F -> r = F, g = 0, b = F exactly 3 cycles after the input.
- 1x scale, win (160,120):
  - (160,120) -> addr 0.
  - (479,359) -> addr 76799.
  - (480,359) and (159,120) -> rd_en = 0 and rgb = 0.
- RD_LAT = 3 build:
  - A single-cycle h_sync pulse and a DE rising edge appear on h_sync_out / DE_out exactly 5 cycles later, coincident with the first valid colour.
- Config change:
  - Set scale_sel = 1x at y = 100 -> the remaining rows of that frame still use 2x addressing.
  - 1x takes effect from row 0 of the next frame, after y >= 480 is seen.
- Window at win (400,300), 2x:
  - Clipped at x = 639 and y = 479 -> the last address is (89*320 + 119); no rd_en outside the display.
- Reset held 3 cycles mid-line at x = 200 -> all outputs 0 during reset; the first correct pixel appears RD_LAT+2 cycles after release.
